// File: rtl/fpa_note_display_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpa_note_display_sequencer_if
// Bundle between the music-player voice channels, the note display
// sequencer and the VGA text driver.
//   master : player/driver side. Drives notes, strobes and frame_start.
//            Observes the displayed notes and the shared write port.
//   slave  : sequencer side. The mirror image of master.
// Signals:
//   input_noteN, new_note_available_N  per-voice note index and new-note strobe
//   frame_start                        one-cycle pulse at raster (0,0)
//   cur_noteN, prev_noteN              displayed current/previous notes
//   disp_we/voice/cur/prev             shared display write port
//   busy, ovf_count                    commit in progress, dropped-event count
// ---------------------------------------------------------------------------
interface fpa_note_display_sequencer_if #(
    parameter int NOTE_W = 6,
    parameter int OVF_W  = 8
);
    logic [NOTE_W-1:0] input_note1, input_note2, input_note3;
    logic              new_note_available_1, new_note_available_2, new_note_available_3;
    logic              frame_start;
    logic [NOTE_W-1:0] cur_note1, cur_note2, cur_note3;
    logic [NOTE_W-1:0] prev_note1, prev_note2, prev_note3;
    logic              disp_we;
    logic [1:0]        disp_voice;
    logic [NOTE_W-1:0] disp_cur, disp_prev;
    logic              busy;
    logic [OVF_W-1:0]  ovf_count;

    modport master (
        output input_note1, input_note2, input_note3,
        output new_note_available_1, new_note_available_2, new_note_available_3,
        output frame_start,
        input  cur_note1, cur_note2, cur_note3,
        input  prev_note1, prev_note2, prev_note3,
        input  disp_we, disp_voice, disp_cur, disp_prev,
        input  busy, ovf_count
    );

    modport slave (
        input  input_note1, input_note2, input_note3,
        input  new_note_available_1, new_note_available_2, new_note_available_3,
        input  frame_start,
        output cur_note1, cur_note2, cur_note3,
        output prev_note1, prev_note2, prev_note3,
        output disp_we, disp_voice, disp_cur, disp_prev,
        output busy, ovf_count
    );
endinterface

// File: rtl/fpa_note_display_sequencer.sv
// ---------------------------------------------------------------------------
// fpa_note_display_sequencer
// Captures new notes from three voices and stages them. Commits the staged
// notes to the displayed cur/prev registers only at frame start, so the
// raster never shows a half-updated frame. Commits go through one shared
// write port, one voice per cycle, in round-robin order.
// Ports:
//   clk    system/pixel clock
//   rst_n  asynchronous active-low reset
//   bus    fpa_note_display_sequencer_if.slave (see interface header)
// ---------------------------------------------------------------------------

// Per-voice capture lane: strobe synchronizer, rising-edge detect, staged
// note and pending flag.
module fpa_note_voice_capture #(
    parameter int NOTE_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe,     // possibly asynchronous new-note level
    input  logic [NOTE_W-1:0] note,
    input  logic              commit,     // this voice is committed this cycle
    output logic              pending,
    output logic [NOTE_W-1:0] staged,
    output logic              overwrite   // staged note replaced before commit
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   rise;

    assign rise      = sync_q[SYNC_STAGES-1] & ~last_q;
    // An edge in the same cycle as this voice's commit only re-stages the
    // note. The old value still reaches the display, so nothing is dropped.
    assign overwrite = rise & pending & ~commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pending <= 1'b0;
            staged  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
            last_q <= sync_q[SYNC_STAGES-1];
            if (rise) begin
                staged  <= note;
                pending <= 1'b1;          // a new set wins over a commit clear
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

module fpa_note_display_sequencer #(
    parameter int NOTE_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int OVF_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fpa_note_display_sequencer_if.slave bus
);
    localparam int NV = 3;

    typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [NV-1:0][NOTE_W-1:0] in_note, staged, cur_q, prev_q;
    logic [NV-1:0]            strobe, pending, overwrite, commit_hit;
    logic [NV-1:0]            commit_mask_q, src, sel_onehot;
    logic [1:0]               rr_q, sel;
    logic                     sel_found, issue, busy;
    logic                     disp_we_q;
    logic [1:0]               disp_voice_q;
    logic [NOTE_W-1:0]        disp_cur_q, disp_prev_q;
    logic [OVF_W-1:0]         ovf_q, ovf_next;
    logic [1:0]               ovf_inc;
    logic [OVF_W:0]           ovf_sum;
    logic [2:0]               idx;

    assign in_note = {bus.input_note3, bus.input_note2, bus.input_note1};
    assign strobe  = {bus.new_note_available_3, bus.new_note_available_2,
                      bus.new_note_available_1};

    for (genvar v = 0; v < NV; v++) begin : g_voice
        fpa_note_voice_capture #(
            .NOTE_W      (NOTE_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cap (
            .clk       (clk),
            .rst_n     (rst_n),
            .strobe    (strobe[v]),
            .note      (in_note[v]),
            .commit    (commit_hit[v]),
            .pending   (pending[v]),
            .staged    (staged[v]),
            .overwrite (overwrite[v])
        );
    end

    // Round-robin pick: first set bit of src at or after rr_q, wrapping 2->0.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < NV; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'(NV)) idx = idx - 3'(NV);
            if (!sel_found && src[idx[1:0]]) begin
                sel       = idx[1:0];
                sel_found = 1'b1;
            end
        end
    end

    assign sel_onehot = {{(NV-1){1'b0}}, 1'b1} << sel;
    assign commit_hit = issue ? sel_onehot : '0;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. COMMIT exits once every masked voice has been issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.frame_start && (|pending)) state_d = COMMIT;
            COMMIT:  if (commit_mask_q == '0)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. The write-port registers are loaded one cycle ahead, so a
    // voice is issued on the frame_start edge and each following COMMIT cycle
    // while voices remain. disp_we then lines up exactly with busy.
    always_comb begin
        busy  = (state_q == COMMIT);
        src   = busy ? commit_mask_q : pending;
        issue = sel_found & (busy | bus.frame_start);
    end

    // Saturating dropped-event counter. Several voices can overwrite in the
    // same cycle.
    always_comb begin
        ovf_inc  = {1'b0, overwrite[0]} + {1'b0, overwrite[1]} + {1'b0, overwrite[2]};
        ovf_sum  = {1'b0, ovf_q} + {{(OVF_W-1){1'b0}}, ovf_inc};
        ovf_next = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q         <= '0;
            prev_q        <= '0;
            commit_mask_q <= '0;
            rr_q          <= '0;
            disp_we_q     <= 1'b0;
            disp_voice_q  <= '0;
            disp_cur_q    <= '0;
            disp_prev_q   <= '0;
            ovf_q         <= '0;
        end else begin
            disp_we_q <= issue;
            ovf_q     <= ovf_next;
            if (issue) begin
                // The mask holds voices not yet issued. The voice issued on
                // entry is removed as the pending snapshot is latched.
                commit_mask_q <= src & ~sel_onehot;
                disp_voice_q  <= sel;
                disp_cur_q    <= staged[sel];
                disp_prev_q   <= cur_q[sel];
                cur_q[sel]    <= staged[sel];
                prev_q[sel]   <= cur_q[sel];
                rr_q          <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            end
        end
    end

    assign bus.cur_note1  = cur_q[0];
    assign bus.cur_note2  = cur_q[1];
    assign bus.cur_note3  = cur_q[2];
    assign bus.prev_note1 = prev_q[0];
    assign bus.prev_note2 = prev_q[1];
    assign bus.prev_note3 = prev_q[2];
    assign bus.disp_we    = disp_we_q;
    assign bus.disp_voice = disp_voice_q;
    assign bus.disp_cur   = disp_cur_q;
    assign bus.disp_prev  = disp_prev_q;
    assign bus.busy       = busy;
    assign bus.ovf_count  = ovf_q;
endmodule

// File: tb/tb_fpa_note_display_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpa_note_display_sequencer
// Directed scenarios with hand-computed expectations. Inputs are driven and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fpa_note_display_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fpa_note_display_sequencer_if #(.NOTE_W(6), .OVF_W(8)) bus ();

    fpa_note_display_sequencer #(
        .NOTE_W(6), .SYNC_STAGES(2), .OVF_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Hold the strobes for 5 cycles, then drop them for 5 cycles. This is
    // long enough for capture and for the edge detector to re-arm.
    task automatic strobe_voices(input logic [2:0] m, input logic [5:0] n1, n2, n3);
        if (m[0]) bus.input_note1 = n1;
        if (m[1]) bus.input_note2 = n2;
        if (m[2]) bus.input_note3 = n3;
        bus.new_note_available_1 = m[0];
        bus.new_note_available_2 = m[1];
        bus.new_note_available_3 = m[2];
        repeat (5) @(negedge clk);
        bus.new_note_available_1 = 1'b0;
        bus.new_note_available_2 = 1'b0;
        bus.new_note_available_3 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // One-cycle frame_start; returns at the negedge after it was sampled.
    task automatic frame();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic test_reset();
        bus.input_note1 = '0; bus.input_note2 = '0; bus.input_note3 = '0;
        bus.new_note_available_1 = 1'b0;
        bus.new_note_available_2 = 1'b0;
        bus.new_note_available_3 = 1'b0;
        bus.frame_start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3} !== 36'd0) $display("FAIL rst_notes: got %h want 0", {bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3}); else n_pass++;
        n_checks++; if ({bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== 16'd0) $display("FAIL rst_port: got %h want 0", {bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev}); else n_pass++;
        n_checks++; if (bus.ovf_count !== 8'd0) $display("FAIL rst_ovf: got %0d want 0", bus.ovf_count); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        frame();
        n_checks++; if ({bus.disp_we, bus.busy} !== 2'b00) $display("FAIL rst_idle_frame: got %b want 00", {bus.disp_we, bus.busy}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_single_latency();
        bus.input_note2 = 6'd17;
        bus.new_note_available_2 = 1'b1;
        repeat (2) @(negedge clk);
        // The capture edge coincides with this frame_start, so no commit yet.
        frame();
        n_checks++; if ({bus.disp_we, bus.busy} !== 2'b00) $display("FAIL lat_early_frame: got %b want 00", {bus.disp_we, bus.busy}); else n_pass++;
        repeat (2) @(negedge clk);
        bus.new_note_available_2 = 1'b0;
        repeat (5) @(negedge clk);
        frame();
        n_checks++; if ({bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd1, 6'd17, 6'd0}) $display("FAIL lat_port: got %h want %h", {bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd1, 6'd17, 6'd0}); else n_pass++;
        n_checks++; if ({bus.cur_note2, bus.busy} !== {6'd17, 1'b1}) $display("FAIL lat_cur_busy: got %h want %h", {bus.cur_note2, bus.busy}, {6'd17, 1'b1}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.disp_we, bus.busy} !== 2'b00) $display("FAIL lat_one_cycle: got %b want 00", {bus.disp_we, bus.busy}); else n_pass++;
    endtask

    task automatic test_round_robin();
        // Commit voice index 2 so the pointer wraps back to 0.
        strobe_voices(3'b100, 6'd0, 6'd0, 6'd3);
        frame();
        n_checks++; if ({bus.disp_voice, bus.cur_note3} !== {2'd2, 6'd3}) $display("FAIL rr_pre: got %h want %h", {bus.disp_voice, bus.cur_note3}, {2'd2, 6'd3}); else n_pass++;
        @(negedge clk);
        strobe_voices(3'b111, 6'd5, 6'd9, 6'd40);
        frame();
        n_checks++; if ({bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {2'b11, 2'd0, 6'd5, 6'd0}) $display("FAIL rr_c0: got %h want %h", {bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {2'b11, 2'd0, 6'd5, 6'd0}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {2'b11, 2'd1, 6'd9, 6'd17}) $display("FAIL rr_c1: got %h want %h", {bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {2'b11, 2'd1, 6'd9, 6'd17}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {2'b11, 2'd2, 6'd40, 6'd3}) $display("FAIL rr_c2: got %h want %h", {bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {2'b11, 2'd2, 6'd40, 6'd3}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.disp_we, bus.busy} !== 2'b00) $display("FAIL rr_end: got %b want 00", {bus.disp_we, bus.busy}); else n_pass++;
        n_checks++; if ({bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3} !== {6'd5, 6'd9, 6'd40, 6'd0, 6'd17, 6'd3}) $display("FAIL rr_regs: got %h want %h", {bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3}, {6'd5, 6'd9, 6'd40, 6'd0, 6'd17, 6'd3}); else n_pass++;
        // Pointer is back at 0: voices 2 and 0 pending go 0 then 2.
        strobe_voices(3'b101, 6'd7, 6'd0, 6'd12);
        frame();
        n_checks++; if ({bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd0, 6'd7, 6'd5}) $display("FAIL rr2_c0: got %h want %h", {bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd0, 6'd7, 6'd5}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd2, 6'd12, 6'd40}) $display("FAIL rr2_c2: got %h want %h", {bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd2, 6'd12, 6'd40}); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rr2_end: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_history();
        strobe_voices(3'b010, 6'd0, 6'd20, 6'd0);
        frame();
        n_checks++; if ({bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {2'd1, 6'd20, 6'd9}) $display("FAIL hist_1: got %h want %h", {bus.disp_voice, bus.disp_cur, bus.disp_prev}, {2'd1, 6'd20, 6'd9}); else n_pass++;
        @(negedge clk);
        strobe_voices(3'b010, 6'd0, 6'd33, 6'd0);
        frame();
        n_checks++; if ({bus.disp_cur, bus.disp_prev, bus.cur_note2, bus.prev_note2} !== {6'd33, 6'd20, 6'd33, 6'd20}) $display("FAIL hist_2: got %h want %h", {bus.disp_cur, bus.disp_prev, bus.cur_note2, bus.prev_note2}, {6'd33, 6'd20, 6'd33, 6'd20}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_overwrite();
        strobe_voices(3'b100, 6'd0, 6'd0, 6'd8);
        n_checks++; if (bus.ovf_count !== 8'd0) $display("FAIL ovw_first: got %0d want 0", bus.ovf_count); else n_pass++;
        strobe_voices(3'b100, 6'd0, 6'd0, 6'd11);
        n_checks++; if (bus.ovf_count !== 8'd1) $display("FAIL ovw_count: got %0d want 1", bus.ovf_count); else n_pass++;
        frame();
        n_checks++; if ({bus.disp_voice, bus.disp_cur, bus.disp_prev, bus.cur_note3, bus.prev_note3} !== {2'd2, 6'd11, 6'd12, 6'd11, 6'd12}) $display("FAIL ovw_commit: got %h want %h", {bus.disp_voice, bus.disp_cur, bus.disp_prev, bus.cur_note3, bus.prev_note3}, {2'd2, 6'd11, 6'd12, 6'd11, 6'd12}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_collision();
        strobe_voices(3'b001, 6'd44, 6'd0, 6'd0);
        bus.input_note1 = 6'd50;
        bus.new_note_available_1 = 1'b1;
        repeat (2) @(negedge clk);
        // Capture of 50 lands on the same edge that commits 44.
        frame();
        n_checks++; if ({bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd0, 6'd44, 6'd7}) $display("FAIL coll_commit: got %h want %h", {bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd0, 6'd44, 6'd7}); else n_pass++;
        n_checks++; if ({bus.cur_note1, bus.ovf_count} !== {6'd44, 8'd1}) $display("FAIL coll_cur_ovf: got %h want %h", {bus.cur_note1, bus.ovf_count}, {6'd44, 8'd1}); else n_pass++;
        repeat (2) @(negedge clk);
        bus.new_note_available_1 = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL coll_wait: got %b want 0", bus.busy); else n_pass++;
        frame();
        n_checks++; if ({bus.disp_we, bus.disp_cur, bus.disp_prev, bus.cur_note1, bus.prev_note1, bus.ovf_count} !== {1'b1, 6'd50, 6'd44, 6'd50, 6'd44, 8'd1}) $display("FAIL coll_next: got %h want %h", {bus.disp_we, bus.disp_cur, bus.disp_prev, bus.cur_note1, bus.prev_note1, bus.ovf_count}, {1'b1, 6'd50, 6'd44, 6'd50, 6'd44, 8'd1}); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL coll_end: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_saturation();
        // ovf starts at 1. Strobe i (i >= 2) is overwrite number i-1.
        for (int i = 1; i <= 301; i++) begin
            strobe_voices(3'b010, 6'd0, 6'(i), 6'd0);
            if (i == 254) begin
                n_checks++; if (bus.ovf_count !== 8'd254) $display("FAIL sat_254: got %0d want 254", bus.ovf_count); else n_pass++;
            end
        end
        n_checks++; if (bus.ovf_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", bus.ovf_count); else n_pass++;
        frame();
        n_checks++; if ({bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {2'd1, 6'd45, 6'd33}) $display("FAIL sat_commit: got %h want %h", {bus.disp_voice, bus.disp_cur, bus.disp_prev}, {2'd1, 6'd45, 6'd33}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        strobe_voices(3'b111, 6'd1, 6'd2, 6'd3);
        frame();
        n_checks++; if ({bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd2, 6'd3, 6'd11}) $display("FAIL mid_first: got %h want %h", {bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd2, 6'd3, 6'd11}); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3} !== 36'd0) $display("FAIL mid_notes: got %h want 0", {bus.cur_note1, bus.cur_note2, bus.cur_note3, bus.prev_note1, bus.prev_note2, bus.prev_note3}); else n_pass++;
        n_checks++; if ({bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev, bus.ovf_count} !== 24'd0) $display("FAIL mid_port: got %h want 0", {bus.disp_we, bus.busy, bus.disp_voice, bus.disp_cur, bus.disp_prev, bus.ovf_count}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame();
        n_checks++; if ({bus.disp_we, bus.busy} !== 2'b00) $display("FAIL mid_no_commit: got %b want 00", {bus.disp_we, bus.busy}); else n_pass++;
        @(negedge clk);
        // A rest (note 0) still goes through the write port.
        strobe_voices(3'b100, 6'd0, 6'd0, 6'd0);
        frame();
        n_checks++; if ({bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev} !== {1'b1, 2'd2, 6'd0, 6'd0}) $display("FAIL rest_commit: got %h want %h", {bus.disp_we, bus.disp_voice, bus.disp_cur, bus.disp_prev}, {1'b1, 2'd2, 6'd0, 6'd0}); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_round_robin();
        test_history();
        test_overwrite();
        test_collision();
        test_saturation();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
